degamma_lut_pipe: RTL and testbench

Synthesizable degamma stage feeding the TCON output path. It receives the vsync/de/RGB pixel stream, applies a per-channel piecewise-linear degamma curve and emits a latency-matched vsync/de/RGB stream. That stream is the one the output PPM monitor captures and checks. Curves are held in programmable knot tables, double-buffered, so updates take effect only at frame boundaries.

---
 rtl/degamma_pkg.sv | 22 ++
 rtl/degamma_interp.sv | 63 ++++++
 rtl/degamma_lut_pipe.sv | 125 ++++++++++++
 tb/tb_degamma_lut_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/degamma_pkg.sv
// Shared constants, channel encoding and helpers for the degamma LUT pipeline.
package degamma_pkg;

  localparam int unsigned DW_DEF   = 8;
  localparam int unsigned FRAC_DEF = 4;
  localparam int unsigned KNOTS    = 2**(DW_DEF-FRAC_DEF) + 1;
  localparam int unsigned AW       = 5;
  // y*(2**FRAC) plus rounding term never exceeds this width
  localparam int unsigned ACC_W    = DW_DEF + 1 + FRAC_DEF + 1;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } ch_e;

  function automatic int unsigned identity_knot(input int unsigned k,
                                                input int unsigned frac = FRAC_DEF);
    return k << frac;
  endfunction

endpackage

// File: rtl/degamma_interp.sv
// One colour channel: knot select (S2) then interpolate, round, saturate (S3).
module degamma_interp
  import degamma_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned FRAC  = FRAC_DEF,
  parameter int unsigned KNOTS = degamma_pkg::KNOTS,
  parameter int unsigned AW    = degamma_pkg::AW,
  parameter int unsigned ACC_W = degamma_pkg::ACC_W
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [KNOTS-1:0][DW:0] knots,
  input  logic [DW-1:0]         pix,
  input  logic                  de,
  input  logic                  bypass,
  output logic [DW-1:0]         dout
);

  logic [AW-1:0]          idx;
  logic [DW:0]            y0, y1;
  logic [FRAC-1:0]        f;
  logic [DW-1:0]          pix_s2;
  logic [ACC_W-1:0]       w0, acc;
  logic [ACC_W-FRAC-1:0]  res;
  logic [DW-1:0]          sat;

  assign idx = AW'(pix[DW-1:FRAC]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      y0     <= '0;
      y1     <= '0;
      f      <= '0;
      pix_s2 <= '0;
    end else begin
      y0     <= knots[idx];
      y1     <= knots[idx + 1'b1];
      f      <= pix[FRAC-1:0];
      pix_s2 <= pix;
    end
  end

  always_comb begin
    w0  = ACC_W'(2**FRAC) - ACC_W'(f);
    acc = ACC_W'(y0) * w0 + ACC_W'(y1) * ACC_W'(f) + ACC_W'(2**(FRAC-1));
    res = acc[ACC_W-1:FRAC];
    sat = (|res[ACC_W-FRAC-1:DW]) ? '1 : res[DW-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout <= '0;
    end else if (!de) begin
      dout <= '0;
    end else if (bypass) begin
      dout <= pix_s2;
    end else begin
      dout <= sat;
    end
  end

endmodule

// File: rtl/degamma_lut_pipe.sv
// Degamma stage: double-buffered per-channel knot tables swapped on vsync rise,
// three interpolating channels and a 3-cycle matched vsync/de delay.
module degamma_lut_pipe
  import degamma_pkg::*;
#(
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned FRAC = FRAC_DEF,
  parameter int unsigned AW   = degamma_pkg::AW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          vsync_in,
  input  logic          de_in,
  input  logic [DW-1:0] r_in,
  input  logic [DW-1:0] g_in,
  input  logic [DW-1:0] b_in,
  input  logic          lut_wr_en,
  input  logic [1:0]    lut_wr_ch,
  input  logic [AW-1:0] lut_wr_addr,
  input  logic [DW:0]   lut_wr_data,
  input  logic          lut_commit,
  input  logic          bypass,
  output logic          vsync_out,
  output logic          de_out,
  output logic [DW-1:0] r_out,
  output logic [DW-1:0] g_out,
  output logic [DW-1:0] b_out,
  output logic          lut_pending
);

  localparam int unsigned NKNOTS = 2**(DW-FRAC) + 1;
  localparam int unsigned NCH    = 3;

  typedef logic [NKNOTS-1:0][DW:0] table_t;

  table_t        active [NCH];
  table_t        shadow [NCH];
  logic          vsync_d, frame_start, bypass_q, wr_ok;
  logic          vsync_s1, de_s1, vsync_s2, de_s2;
  logic [DW-1:0] pix_s1 [NCH];
  logic [DW-1:0] dout   [NCH];

  assign frame_start = vsync_in & ~vsync_d;
  assign wr_ok       = lut_wr_en && (lut_wr_ch <= CH_B) &&
                       (32'(lut_wr_addr) < NKNOTS);

  // Swap reads shadow before this edge's write lands, so a write on the
  // swap cycle stays in shadow only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        for (int unsigned k = 0; k < NKNOTS; k++) begin
          active[c][k] <= (DW+1)'(identity_knot(k, FRAC));
          shadow[c][k] <= (DW+1)'(identity_knot(k, FRAC));
        end
      end
      vsync_d     <= 1'b0;
      lut_pending <= 1'b0;
      bypass_q    <= 1'b0;
    end else begin
      vsync_d <= vsync_in;
      if (frame_start) begin
        if (lut_pending || lut_commit) begin
          for (int unsigned c = 0; c < NCH; c++) begin
            active[c] <= shadow[c];
          end
        end
        lut_pending <= 1'b0;
        bypass_q    <= bypass;
      end else if (lut_commit) begin
        lut_pending <= 1'b1;
      end
      if (wr_ok) begin
        shadow[lut_wr_ch][lut_wr_addr] <= lut_wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vsync_s1  <= 1'b0;
      de_s1     <= 1'b0;
      vsync_s2  <= 1'b0;
      de_s2     <= 1'b0;
      vsync_out <= 1'b0;
      de_out    <= 1'b0;
      for (int unsigned c = 0; c < NCH; c++) begin
        pix_s1[c] <= '0;
      end
    end else begin
      vsync_s1  <= vsync_in;
      de_s1     <= de_in;
      vsync_s2  <= vsync_s1;
      de_s2     <= de_s1;
      vsync_out <= vsync_s2;
      de_out    <= de_s2;
      pix_s1[0] <= r_in;
      pix_s1[1] <= g_in;
      pix_s1[2] <= b_in;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    degamma_interp #(
      .DW    (DW),
      .FRAC  (FRAC),
      .KNOTS (NKNOTS),
      .AW    (AW),
      .ACC_W (DW + FRAC + 2)
    ) u_interp (
      .clk    (clk),
      .rstn   (rstn),
      .knots  (active[c]),
      .pix    (pix_s1[c]),
      .de     (de_s2),
      .bypass (bypass_q),
      .dout   (dout[c])
    );
  end

  assign r_out = dout[0];
  assign g_out = dout[1];
  assign b_out = dout[2];

endmodule

// File: tb/tb_degamma_lut_pipe.sv
// Scoreboard bench for degamma_lut_pipe: directed pixels push hand-computed
// results; a monitor pops on de_out and also checks the vsync/de delay.
module tb_degamma_lut_pipe;

  logic       clk = 1'b0;
  logic       rstn;
  logic       vsync_in, de_in;
  logic [7:0] r_in, g_in, b_in;
  logic       lut_wr_en;
  logic [1:0] lut_wr_ch;
  logic [4:0] lut_wr_addr;
  logic [8:0] lut_wr_data;
  logic       lut_commit, bypass;
  logic       vsync_out, de_out, lut_pending;
  logic [7:0] r_out, g_out, b_out;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } px_t;

  px_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] dly0, dly1, dly2;

  always #5 clk = ~clk;

  degamma_lut_pipe #(.DW(8), .FRAC(4), .AW(5)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .vsync_in    (vsync_in),
    .de_in       (de_in),
    .r_in        (r_in),
    .g_in        (g_in),
    .b_in        (b_in),
    .lut_wr_en   (lut_wr_en),
    .lut_wr_ch   (lut_wr_ch),
    .lut_wr_addr (lut_wr_addr),
    .lut_wr_data (lut_wr_data),
    .lut_commit  (lut_commit),
    .bypass      (bypass),
    .vsync_out   (vsync_out),
    .de_out      (de_out),
    .r_out       (r_out),
    .g_out       (g_out),
    .b_out       (b_out),
    .lut_pending (lut_pending)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference 3-stage delay of the driven {vsync, de}
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dly0 <= '0;
      dly1 <= '0;
      dly2 <= '0;
    end else begin
      dly0 <= {vsync_in, de_in};
      dly1 <= dly0;
      dly2 <= dly1;
    end
  end

  initial begin
    px_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rstn) begin
        chk("vsync_out_delay", 32'(vsync_out), 32'(dly2[1]));
        chk("de_out_delay", 32'(de_out), 32'(dly2[0]));
        if (de_out) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pixel", 32'(de_out), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("r_out", 32'(r_out), 32'(e.r));
            chk("g_out", 32'(g_out), 32'(e.g));
            chk("b_out", 32'(b_out), 32'(e.b));
          end
        end else begin
          chk("rgb_zero_when_de_low", {8'd0, r_out, g_out, b_out}, 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      de_in = 1'b0; r_in = '0; g_in = '0; b_in = '0;
    end
  endtask

  task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                     input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    @(negedge clk);
    de_in = 1'b1; r_in = r; g_in = g; b_in = b;
    exp_q.push_back('{er, eg, eb});
  endtask

  task automatic wr(input logic [1:0] ch, input logic [4:0] addr, input logic [8:0] data);
    @(negedge clk);
    de_in = 1'b0;
    lut_wr_en = 1'b1; lut_wr_ch = ch; lut_wr_addr = addr; lut_wr_data = data;
    @(negedge clk);
    lut_wr_en = 1'b0;
  endtask

  task automatic commit();
    @(negedge clk);
    de_in = 1'b0; lut_commit = 1'b1;
    @(negedge clk);
    lut_commit = 1'b0;
  endtask

  task automatic vs();
    @(negedge clk);
    de_in = 1'b0; vsync_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vsync_in = 1'b0;
  endtask

  // Write, commit and vsync rise all on the same clock edge
  task automatic boundary_combo(input logic [1:0] ch, input logic [4:0] addr, input logic [8:0] data);
    @(negedge clk);
    de_in = 1'b0; vsync_in = 1'b1; lut_commit = 1'b1;
    lut_wr_en = 1'b1; lut_wr_ch = ch; lut_wr_addr = addr; lut_wr_data = data;
    @(negedge clk);
    lut_commit = 1'b0; lut_wr_en = 1'b0;
    @(negedge clk);
    vsync_in = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; vsync_in = 1'b0; de_in = 1'b0;
    r_in = '0; g_in = '0; b_in = '0;
    lut_wr_en = 1'b0; lut_wr_ch = '0; lut_wr_addr = '0; lut_wr_data = '0;
    lut_commit = 1'b0; bypass = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {21'd0, vsync_out, de_out, r_out, g_out, b_out}, 32'd0);
    chk("reset_pending", 32'(lut_pending), 32'd0);
    rstn = 1'b1;

    // Identity after reset
    idle(3);
    vs();
    pix(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
    pix(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    pix(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    idle(4);

    // Interpolation on R: 0x48 -> (16*8 + 48*8 + 8) >> 4 = 0x20
    wr(2'd0, 5'd4, 9'h010);
    wr(2'd0, 5'd5, 9'h030);
    commit();
    chk("pending_after_commit", 32'(lut_pending), 32'd1);
    vs();
    chk("pending_after_swap", 32'(lut_pending), 32'd0);
    pix(8'h48, 8'h48, 8'h48, 8'h20, 8'h48, 8'h48);
    idle(4);

    // Saturation on B knot16
    wr(2'd2, 5'd16, 9'h1FF);
    commit();
    vs();
    pix(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    pix(8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0);
    pix(8'h48, 8'h48, 8'h48, 8'h20, 8'h48, 8'h48);
    idle(4);

    // Commit mid-frame: no change until the vsync rise
    wr(2'd0, 5'd8, 9'h020);
    commit();
    chk("pending_midframe", 32'(lut_pending), 32'd1);
    pix(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
    pix(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
    idle(4);
    vs();
    chk("pending_cleared", 32'(lut_pending), 32'd0);
    pix(8'h80, 8'h80, 8'h80, 8'h20, 8'h80, 8'h80);
    idle(4);

    // Simultaneous write/commit/vsync: active gets pre-write shadow 0x040
    wr(2'd0, 5'd8, 9'h040);
    boundary_combo(2'd0, 5'd8, 9'h050);
    chk("pending_combo", 32'(lut_pending), 32'd0);
    pix(8'h80, 8'h80, 8'h80, 8'h40, 8'h80, 8'h80);
    idle(4);
    commit();
    vs();
    pix(8'h80, 8'h80, 8'h80, 8'h50, 8'h80, 8'h80);
    idle(4);

    // Bypass is frame-latched
    bypass = 1'b1;
    pix(8'h48, 8'h48, 8'h48, 8'h20, 8'h48, 8'h48);
    idle(4);
    vs();
    pix(8'h48, 8'h48, 8'h48, 8'h48, 8'h48, 8'h48);
    pix(8'h80, 8'h80, 8'hFF, 8'h80, 8'h80, 8'hFF);
    idle(4);
    bypass = 1'b0;
    vs();
    pix(8'h48, 8'h48, 8'h48, 8'h20, 8'h48, 8'h48);
    idle(4);

    // Dropped writes: ch=3 and out-of-range address
    wr(2'd3, 5'd4, 9'h1FF);
    wr(2'd0, 5'd20, 9'h000);
    commit();
    vs();
    pix(8'h48, 8'h48, 8'h48, 8'h20, 8'h48, 8'h48);
    pix(8'h80, 8'h80, 8'hF0, 8'h50, 8'h80, 8'hF0);
    idle(4);

    // Async reset mid-frame while a commit is pending
    wr(2'd0, 5'd8, 9'h077);
    commit();
    chk("pending_before_reset", 32'(lut_pending), 32'd1);
    pix(8'h80, 8'h80, 8'h80, 8'h50, 8'h80, 8'h80);
    pix(8'h80, 8'h80, 8'h80, 8'h50, 8'h80, 8'h80);
    pix(8'h80, 8'h80, 8'h80, 8'h50, 8'h80, 8'h80);
    @(negedge clk);
    rstn = 1'b0; de_in = 1'b0;
    #1;
    chk("reset_midframe_outputs", {21'd0, vsync_out, de_out, r_out, g_out, b_out}, 32'd0);
    chk("reset_midframe_pending", 32'(lut_pending), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    vs();
    pix(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
    pix(8'h48, 8'h48, 8'hFF, 8'h48, 8'h48, 8'hFF);
    idle(6);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
